// File: rtl/seqmult_arbiter_pkg.sv
// Shared types and default sizes for the sequential-multiplier arbiter.
package seqmult_pkg;

  typedef enum logic [2:0] {IDLE, GRANT, START, HOLD, WAIT, DONE} arb_state_t;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

endpackage

// File: rtl/seqmult_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any        = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/seqmult_arbiter.sv
// Shares one start/ready sequential multiplier between N requesters using
// round-robin arbitration; returns the product with a one-cycle done pulse.
module seqmult_arbiter
  import seqmult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [2*W-1:0] p_out,
  output logic           busy,
  output logic           mult_start,
  output logic [W-1:0]   mult_a,
  output logic [W-1:0]   mult_b,
  input  logic           mult_ready,
  input  logic [2*W-1:0] mult_p
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   widx_q, widx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    done_q, done_d;
  logic [2*W-1:0]  p_out_q, p_out_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic [W-1:0]    ma_q, ma_d;
  logic [W-1:0]    mb_q, mb_d;

  logic [N-1:0]    pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    grant_d = '0;
    done_d  = '0;
    p_out_d = p_out_q;
    busy_d  = busy_q;
    start_d = start_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    case (state_q)
      IDLE: begin
        if (pick_any && mult_ready) begin
          state_d = GRANT;
          grant_d = pick_oh;
          widx_d  = pick_idx;
          ma_d    = a_in[int'(pick_idx)*W +: W];
          mb_d    = b_in[int'(pick_idx)*W +: W];
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        state_d = START;
        start_d = 1'b1;
      end
      // Start stays high until the multiplier acknowledges, plus one HOLD cycle.
      START: if (!mult_ready) state_d = HOLD;
      HOLD: begin
        state_d = WAIT;
        start_d = 1'b0;
      end
      WAIT: begin
        if (mult_ready) begin
          state_d = DONE;
          done_d  = {{(N-1){1'b0}}, 1'b1} << widx_q;
          p_out_d = mult_p;
          ptr_d   = (widx_q == IW'(N-1)) ? '0 : widx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      widx_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      p_out_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      p_out_q <= p_out_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign p_out      = p_out_q;
  assign busy       = busy_q;
  assign mult_start = start_q;
  assign mult_a     = ma_q;
  assign mult_b     = mb_q;

endmodule
